// File: rtl/spi_port_defs.sv
`default_nettype none
// ============================================================================
//  Module   : spi_port_defs (package)
//  Purpose  : Register offsets, bit positions and FSM encodings shared by the
//             SPI master port and its shift engine.
//  Revision : 1.0  initial release
// ============================================================================
package spi_port_defs;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int CTRL_CS_EN_BIT  = 7;
    localparam int CTRL_CS_SEL_MSB = 2;
    localparam int CTRL_CS_SEL_LSB = 0;
    // Only cs_en and cs_sel are stored; the remaining CTRL bits read as 0.
    localparam logic [7:0] CTRL_WMASK = 8'h87;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_engine
//  Purpose  : Mode-0, MSB-first byte shifter with programmable half-period
//             and double-flop miso synchronizer.
//  Revision : 1.0  initial release
// ============================================================================
module spi_shift_engine
    import spi_port_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic [7:0] i_div,
    input  logic       i_miso,
    output logic       o_busy,
    output logic [7:0] o_rx_byte,
    output logic       o_done,
    output logic       o_sclk,
    output logic       o_mosi
);

    spi_state_e r_state;
    spi_state_e w_state_nxt;

    logic [7:0] r_phase;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_rx_bit;
    logic       r_miso_s1;
    logic       r_miso_s2;

    logic w_load;
    logic w_rise;
    logic w_fall;
    logic w_done;
    logic w_phase_zero;

    assign w_phase_zero = (r_phase == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_phase_zero) begin
                    w_rise      = 1'b1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_phase_zero) begin
                    w_fall = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= 8'd0;
            r_shift   <= 8'd0;
            r_bit     <= 3'd0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_rx_bit  <= 1'b0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= i_miso;
            r_miso_s2 <= r_miso_s1;

            // Divider is re-read at every reload so DIV writes land on the next half-period.
            if (w_load) begin
                r_shift <= i_tx_byte;
                r_mosi  <= i_tx_byte[7];
                r_phase <= i_div;
                r_bit   <= 3'd0;
            end else if (r_state != ST_IDLE) begin
                if (w_phase_zero) begin
                    r_phase <= i_div;
                end else begin
                    r_phase <= r_phase - 8'd1;
                end
            end

            if (w_rise) begin
                r_sclk   <= 1'b1;
                r_rx_bit <= r_miso_s2;
            end

            if (w_fall) begin
                r_sclk  <= 1'b0;
                r_shift <= {r_shift[6:0], r_rx_bit};
                r_bit   <= r_bit + 3'd1;
                if (!w_done) begin
                    r_mosi <= r_shift[6];
                end
            end
        end
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign o_rx_byte = {r_shift[6:0], r_rx_bit};
    assign o_done    = w_done;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;

endmodule
`default_nettype wire

// File: rtl/spi_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_port
//  Purpose  : Port-bus register front end (decode, access qualification,
//             chip selects) around the SPI shift engine.
//  Revision : 1.0  initial release
// ============================================================================
module spi_master_port
    import spi_port_defs::*;
#(
    parameter logic [7:0] BASE_PORT = 8'h10,
    parameter int         NUM_CS    = 4,
    parameter logic [7:0] DIV_RESET = 8'd9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic              write_strobe,
    input  logic [7:0]        out_port,
    input  logic              read_strobe,
    output logic [7:0]        in_port,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);

    logic              r_prev_ws;
    logic              r_prev_rs;
    logic [7:0]        r_prev_pid;
    logic [7:0]        r_rxdata;
    logic [7:0]        r_ctrl;
    logic [7:0]        r_div;
    logic              r_ovr;
    logic [NUM_CS-1:0] r_cs_n;

    logic              w_pid_changed;
    logic              w_wr_evt;
    logic              w_rd_evt;
    logic [8:0]        w_off_full;
    logic              w_mapped;
    logic [1:0]        w_off;
    logic              w_wr_data;
    logic              w_wr_ctrl;
    logic              w_wr_div;
    logic              w_rd_status;
    logic              w_start;
    logic              w_busy;
    logic              w_done;
    logic [7:0]        w_rx_byte;
    logic [7:0]        w_ctrl_nxt;
    logic [NUM_CS-1:0] w_cs_n_nxt;

    // A strobe held over two cycles on the same port is one access.
    assign w_pid_changed = (port_id != r_prev_pid);
    assign w_wr_evt      = write_strobe && (!r_prev_ws || w_pid_changed);
    assign w_rd_evt      = read_strobe  && (!r_prev_rs || w_pid_changed);

    assign w_off_full  = {1'b0, port_id} - {1'b0, BASE_PORT};
    assign w_mapped    = (w_off_full < 9'd4);
    assign w_off       = w_off_full[1:0];

    assign w_wr_data   = w_wr_evt && w_mapped && (w_off == REG_DATA);
    assign w_wr_ctrl   = w_wr_evt && w_mapped && (w_off == REG_CTRL);
    assign w_wr_div    = w_wr_evt && w_mapped && (w_off == REG_DIV);
    assign w_rd_status = w_rd_evt && w_mapped && (w_off == REG_STATUS);
    assign w_start     = w_wr_data && !w_busy;

    assign w_ctrl_nxt  = w_wr_ctrl ? (out_port & CTRL_WMASK) : r_ctrl;

    always_comb begin
        w_cs_n_nxt = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_ctrl_nxt[CTRL_CS_EN_BIT] &&
                (w_ctrl_nxt[CTRL_CS_SEL_MSB:CTRL_CS_SEL_LSB] == 3'(i))) begin
                w_cs_n_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_ws  <= 1'b0;
            r_prev_rs  <= 1'b0;
            r_prev_pid <= 8'd0;
            r_rxdata   <= 8'd0;
            r_ctrl     <= 8'd0;
            r_div      <= DIV_RESET;
            r_ovr      <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_prev_ws  <= write_strobe;
            r_prev_rs  <= read_strobe;
            r_prev_pid <= port_id;
            r_ctrl     <= w_ctrl_nxt;
            r_cs_n     <= w_cs_n_nxt;
            if (w_done) begin
                r_rxdata <= w_rx_byte;
            end
            if (w_wr_div) begin
                r_div <= out_port;
            end
            if (w_wr_data && w_busy) begin
                r_ovr <= 1'b1;
            end else if (w_rd_status) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        in_port = 8'd0;
        if (w_mapped) begin
            case (w_off)
                REG_DATA:   in_port = r_rxdata;
                REG_CTRL:   in_port = r_ctrl;
                REG_STATUS: begin
                    in_port[STAT_BUSY_BIT] = w_busy;
                    in_port[STAT_OVR_BIT]  = r_ovr;
                end
                REG_DIV:    in_port = r_div;
                default:    in_port = 8'd0;
            endcase
        end
    end

    spi_shift_engine u_engine (
        .clk       (clk),
        .rst       (reset),
        .i_start   (w_start),
        .i_tx_byte (out_port),
        .i_div     (r_div),
        .i_miso    (spi_miso),
        .o_busy    (w_busy),
        .o_rx_byte (w_rx_byte),
        .o_done    (w_done),
        .o_sclk    (spi_sclk),
        .o_mosi    (spi_mosi)
    );

    assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_port
//  Purpose  : Directed bench with a cycle-indexed reference model of the
//             SPI master port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_port;

    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] A_DATA = BASE + 8'd0;
    localparam logic [7:0] A_CTRL = BASE + 8'd1;
    localparam logic [7:0] A_STAT = BASE + 8'd2;
    localparam logic [7:0] A_DIV  = BASE + 8'd3;
    // Bit captured at a sclk rise left the miso pin three clk edges earlier
    // (two synchronizer flops plus the capture flop).
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id = 8'd0;
    logic       ws = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] out_port = 8'd0;
    logic [7:0] in_port;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [3:0] cs_n;
    logic       lb = 1'b0;
    logic       miso_val = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    assign miso = lb ? mosi : miso_val;

    always #5 clk = ~clk;

    spi_master_port #(.BASE_PORT(BASE), .NUM_CS(4), .DIV_RESET(8'd9)) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (ws),
        .out_port     (out_port),
        .read_strobe  (rs),
        .in_port      (in_port),
        .spi_sclk     (sclk),
        .spi_mosi     (mosi),
        .spi_miso     (miso),
        .spi_cs_n     (cs_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (state indexed by cycle number) -------
    int         cyc = 0;
    bit         chk_en = 0;
    logic [7:0] m_rx, m_ctrl, m_div, m_tx, m_ppid;
    bit         m_ovr, m_act, m_last_mosi, m_pws, m_prs;
    int         m_s, m_d;
    bit         hist [0:16383];

    function automatic bit in_xfer(input int c);
        return m_act && (c >= m_s) && (c < m_s + 16 * (m_d + 1));
    endfunction

    function automatic logic [7:0] expected_rx();
        logic [7:0] r;
        r = 8'd0;
        for (int k = 0; k < 8; k++) begin
            r[7-k] = hist[m_s + (2 * k + 1) * (m_d + 1) - SYNC_LAT];
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit bprev, wev, rev, mapped;
        int off;
        if (cyc < 16384) hist[cyc] = miso;
        cyc++;
        if (reset) begin
            m_rx = 8'd0; m_ctrl = 8'd0; m_div = 8'd9; m_ovr = 0; m_act = 0;
            m_last_mosi = 0; m_pws = 0; m_prs = 0; m_ppid = 8'd0;
        end else begin
            bprev = in_xfer(cyc - 1);
            if (m_act && cyc == m_s + 16 * (m_d + 1)) begin
                m_rx = expected_rx();
                m_last_mosi = m_tx[0];
                m_act = 0;
            end
            wev = ws && (!m_pws || port_id != m_ppid);
            rev = rs && (!m_prs || port_id != m_ppid);
            off = int'(port_id) - int'(BASE);
            mapped = (off >= 0) && (off <= 3);
            if (rev && mapped && off == 2) m_ovr = 0;
            if (wev && mapped) begin
                case (off)
                    0: if (bprev) m_ovr = 1;
                       else begin m_act = 1; m_s = cyc; m_d = int'(m_div); m_tx = out_port; end
                    1: m_ctrl = out_port & 8'h87;
                    3: m_div = out_port;
                    default: ;
                endcase
            end
            m_pws = ws; m_prs = rs; m_ppid = port_id;
        end
        chk_en = 1;
    end

    always @(negedge clk) begin : compare
        logic [7:0] e_in;
        logic [3:0] e_cs;
        bit e_sclk, e_mosi;
        int off, h;
        if (chk_en) begin
            if (in_xfer(cyc)) begin
                h = (cyc - m_s) / (m_d + 1);
                e_sclk = (h % 2) == 1;
                e_mosi = m_tx[7 - h / 2];
            end else begin
                e_sclk = 0;
                e_mosi = m_last_mosi;
            end
            e_cs = 4'hF;
            if (m_ctrl[7] && m_ctrl[2:0] < 3'd4) e_cs[m_ctrl[1:0]] = 1'b0;
            off = int'(port_id) - int'(BASE);
            case (off)
                0: e_in = m_rx;
                1: e_in = m_ctrl;
                2: e_in = {6'd0, m_ovr, in_xfer(cyc)};
                3: e_in = m_div;
                default: e_in = 8'd0;
            endcase
            check("sclk", 32'(sclk), 32'(e_sclk));
            check("mosi", 32'(mosi), 32'(e_mosi));
            check("cs_n", 32'(cs_n), 32'(e_cs));
            check("in_port", 32'(in_port), 32'(e_in));
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold);
        @(posedge clk); #2;
        port_id = a; out_port = d; ws = 1'b1;
        repeat (hold) @(posedge clk);
        #2 ws = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #2;
        port_id = a; rs = 1'b1;
        @(negedge clk); d = in_port;
        @(posedge clk); #2 rs = 1'b0;
    endtask

    // Peeks STATUS (no read strobe) until busy drops; tallies sclk rises and mosi at each rise.
    task automatic measure(output int bc, output int rises, output logic [7:0] mb);
        logic ps;
        bit seen, fin;
        bc = 0; rises = 0; mb = 8'd0; ps = 1'b0; seen = 0; fin = 0;
        port_id = A_STAT;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(negedge clk);
            if (in_port[0]) begin bc++; seen = 1; end
            if (sclk && !ps) begin rises++; mb = {mb[6:0], mosi}; end
            ps = sclk;
            if (seen && !in_port[0]) fin = 1;
        end
        check("xfer_done", 32'(fin), 32'd1);
    endtask

    task automatic count_rises(input int ncyc, output int rises);
        logic ps;
        ps = sclk; rises = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] d, mb;
        int bc, rises;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        rd(A_DATA, d); check("rst_data", 32'(d), 32'h00);
        rd(A_CTRL, d); check("rst_ctrl", 32'(d), 32'h00);
        rd(A_STAT, d); check("rst_status", 32'(d), 32'h00);
        rd(A_DIV, d);  check("rst_div", 32'(d), 32'h09);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_sclk", 32'(sclk), 32'h0);

        // Loopback at clk/2: the synchronizer delays each captured bit by one
        // bit time, so the received byte is A5 shifted right with a leading 0.
        lb = 1'b1;
        wr(A_CTRL, 8'h81, 1);
        @(negedge clk); check("cs_sel1", 32'(cs_n), 32'b1101);
        wr(A_DIV, 8'h00, 1);
        wr(A_DATA, 8'hA5, 1);
        measure(bc, rises, mb);
        check("a5_busy", 32'(bc), 32'd16);
        check("a5_rises", 32'(rises), 32'd8);
        check("a5_mosi", 32'(mb), 32'hA5);
        rd(A_DATA, d); check("a5_rx", 32'(d), 32'h52);

        lb = 1'b0; miso_val = 1'b1;
        wr(A_DIV, 8'h03, 1);
        wr(A_DATA, 8'h3C, 1);
        measure(bc, rises, mb);
        check("3c_busy", 32'(bc), 32'd64);
        check("3c_rises", 32'(rises), 32'd8);
        check("3c_mosi", 32'(mb), 32'h3C);
        rd(A_DATA, d); check("3c_rx", 32'(d), 32'hFF);

        lb = 1'b1;
        wr(A_DATA, 8'h11, 1);
        wr(A_DATA, 8'h22, 1);
        port_id = A_STAT;
        @(negedge clk); check("ovr_mid_status", 32'(in_port), 32'h03);
        measure(bc, rises, mb);
        count_rises(20, rises); check("ovr_no_2nd_xfer", 32'(rises), 32'd0);
        rd(A_DATA, d); check("ovr_rx", 32'(d), 32'h11);
        rd(A_STAT, d); check("ovr_read1", 32'(d), 32'h02);
        rd(A_STAT, d); check("ovr_read2", 32'(d), 32'h00);

        wr(A_DATA, 8'h5A, 2);
        measure(bc, rises, mb);
        check("hold_rises", 32'(rises), 32'd8);
        check("hold_mosi", 32'(mb), 32'h5A);
        count_rises(20, rises); check("hold_single", 32'(rises), 32'd0);
        rd(A_STAT, d); check("hold_status", 32'(d), 32'h00);
        rd(A_DATA, d); check("hold_rx", 32'(d), 32'h5A);

        // Abort in the HIGH phase of bit 3 (fourth sclk rise).
        wr(A_DATA, 8'hF0, 1);
        rises = 0;
        begin
            logic ps;
            ps = 1'b0;
            for (int i = 0; i < 200 && rises < 4; i++) begin
                @(negedge clk);
                if (sclk && !ps) rises++;
                ps = sclk;
            end
        end
        check("abort_reach_bit3", 32'(rises), 32'd4);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        port_id = A_STAT;
        @(negedge clk);
        check("abort_sclk", 32'(sclk), 32'h0);
        check("abort_cs_n", 32'(cs_n), 32'hF);
        check("abort_status", 32'(in_port), 32'h00);
        @(posedge clk); #2 port_id = A_DATA;
        @(negedge clk); check("abort_rx", 32'(in_port), 32'h00);
        count_rises(40, rises); check("abort_no_edges", 32'(rises), 32'd0);
        rd(A_DIV, d); check("abort_div", 32'(d), 32'h09);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
